// File: rtl/prbs_checker.sv
// Self-synchronising PRBS word checker. It locks onto the received pattern, then
// counts bit errors and checked words with saturating counters.
module prbs_checker #(
  parameter int DATA_WIDTH   = 10,
  parameter int POLY_LENGTH  = 9,
  parameter int POLY_TAP     = 5,
  parameter int INV_PATTERN  = 1,
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  input  logic                  clear_cnt,
  output logic                  locked,
  output logic                  err_flag,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  localparam int PW   = $clog2(DATA_WIDTH + 1);
  localparam int RMAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t                 state_q;
  logic [POLY_LENGTH-1:0] hist_q, hist_d;
  logic [RW-1:0]          clean_run_q, bad_run_q;
  logic                   locked_q, err_flag_q;
  logic [CNT_WIDTH-1:0]   err_cnt_q, word_cnt_q;

  logic [POLY_LENGTH-1:0] h;
  logic [DATA_WIDTH-1:0]  errs;
  logic                   r, p, clean;
  logic [PW-1:0]          nerr;
  logic [CNT_WIDTH:0]     esum, wsum;
  logic [CNT_WIDTH-1:0]   err_sat, wc_sat;

  // Bits are walked MSB (first in time) to LSB; LOCKED feeds the history with
  // its own predictions so line errors cannot corrupt the reference.
  always_comb begin
    h    = hist_q;
    errs = '0;
    r    = 1'b0;
    p    = 1'b0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      r       = data_in[i] ^ (INV_PATTERN != 0);
      p       = h[POLY_LENGTH-1] ^ h[POLY_TAP-1];
      errs[i] = r ^ p;
      h       = {h[POLY_LENGTH-2:0], (state_q == LOCKED) ? p : r};
    end
    hist_d = h;
    clean  = (errs == '0) && (hist_d != '0);
    nerr   = '0;
    for (int i = 0; i < DATA_WIDTH; i++) nerr = nerr + PW'(errs[i]);
    esum    = {1'b0, err_cnt_q} + (CNT_WIDTH+1)'(nerr);
    wsum    = {1'b0, word_cnt_q} + (CNT_WIDTH+1)'(1);
    err_sat = esum[CNT_WIDTH] ? '1 : esum[CNT_WIDTH-1:0];
    wc_sat  = wsum[CNT_WIDTH] ? '1 : wsum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      hist_q      <= '0;
      clean_run_q <= '0;
      bad_run_q   <= '0;
      locked_q    <= 1'b0;
      err_flag_q  <= 1'b0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      err_flag_q <= 1'b0;
      if (data_valid) begin
        hist_q <= hist_d;
        case (state_q)
          SEARCH: begin
            if (!clean) clean_run_q <= '0;
            else if (clean_run_q == RW'(LOCK_COUNT - 1)) begin
              state_q     <= LOCKED;
              locked_q    <= 1'b1;
              clean_run_q <= '0;
              bad_run_q   <= '0;
            end else clean_run_q <= clean_run_q + RW'(1);
          end
          default: begin
            err_flag_q <= (errs != '0);
            if (errs == '0) bad_run_q <= '0;
            else if (bad_run_q == RW'(UNLOCK_COUNT - 1)) begin
              state_q     <= SEARCH;
              locked_q    <= 1'b0;
              bad_run_q   <= '0;
              clean_run_q <= '0;
            end else bad_run_q <= bad_run_q + RW'(1);
            err_cnt_q  <= err_sat;
            word_cnt_q <= wc_sat;
          end
        endcase
      end
      // Clear wins over any contribution from a word sampled this edge.
      if (clear_cnt) begin
        err_cnt_q  <= '0;
        word_cnt_q <= '0;
      end
    end
  end

  assign locked   = locked_q;
  assign err_flag = err_flag_q;
  assign err_cnt  = err_cnt_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a default-width instance plus a 4-bit counter
// instance sharing the same stimulus for saturation checks.
module tb_prbs_checker;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  data_in;
  logic        data_valid, clear_cnt;
  logic        locked, err_flag, s_locked, s_err_flag;
  logic [31:0] err_cnt, word_cnt;
  logic [3:0]  s_err_cnt, s_word_cnt;
  logic [8:0]  gs;
  logic [9:0]  w;
  logic        seen_lock;
  int          checks, errors;

  always #50 clk = ~clk;

  prbs_checker dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .clear_cnt(clear_cnt), .locked(locked), .err_flag(err_flag),
    .err_cnt(err_cnt), .word_cnt(word_cnt)
  );

  prbs_checker #(.CNT_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .clear_cnt(clear_cnt), .locked(s_locked), .err_flag(s_err_flag),
    .err_cnt(s_err_cnt), .word_cnt(s_word_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Inverted PRBS-9 (x^9 + x^5 + 1) reference, MSB first.
  task automatic gen(output logic [9:0] wo);
    logic b;
    for (int i = 9; i >= 0; i--) begin
      b     = gs[8] ^ gs[4];
      gs    = {gs[7:0], b};
      wo[i] = ~b;
    end
  endtask

  task automatic step(input logic [9:0] d, input logic v, input logic c);
    data_in    = d;
    data_valid = v;
    clear_cnt  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int e, input int wc);
    chk({tag, "_err"}, err_cnt, e);
    chk({tag, "_wc"}, word_cnt, wc);
  endtask

  logic [9:0] masks [4];

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; data_in = '0; data_valid = 1'b0; clear_cnt = 1'b0;
    masks[0] = 10'h155; masks[1] = 10'h2AA; masks[2] = 10'h3FF; masks[3] = 10'h001;

    // reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      step(10'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("rst_locked", locked, 0);
      chk("rst_flag", err_flag, 0);
      chk_cnt("rst", 0, 0);
    end
    rst = 1'b0;

    // acquisition: word 1 dirty from zero history, lock on word 9
    gs = 9'h1A5;
    for (int i = 1; i <= 20; i++) begin
      gen(w); step(w, 1'b1, 1'b0);
      if (i == 8) chk("lock_w8", locked, 0);
      if (i == 9) chk("lock_w9", locked, 1);
    end
    chk_cnt("lock", 0, 11);

    // single and triple bit errors while locked
    gen(w); step(w ^ 10'h004, 1'b1, 1'b0);
    chk("e1_flag", err_flag, 1); chk_cnt("e1", 1, 12);
    gen(w); step(w, 1'b1, 1'b0);
    chk("e1_pulse", err_flag, 0);
    step(10'h3FF, 1'b0, 1'b0);
    chk("gap_flag", err_flag, 0); chk_cnt("gap", 1, 13);
    gen(w); step(w ^ 10'h0E0, 1'b1, 1'b0);
    chk("e3_flag", err_flag, 1); chk_cnt("e3", 4, 14); chk("e3_locked", locked, 1);
    gen(w); step(w, 1'b1, 1'b0);
    chk("e3_pulse", err_flag, 0); chk_cnt("e3c", 4, 15);

    // loss of lock after 4 errored words, then relock on continued pattern
    for (int k = 0; k < 4; k++) begin
      gen(w); step(w ^ masks[k], 1'b1, 1'b0);
      chk("loss_locked", locked, (k < 3) ? 1 : 0);
    end
    chk("loss_flag", err_flag, 1);
    chk_cnt("loss", 25, 19);
    step(10'h000, 1'b0, 1'b0);
    chk("loss_gap", locked, 0);
    for (int i = 1; i <= 8; i++) begin
      gen(w); step(w, 1'b1, 1'b0);
      if (i == 4) step(10'h3FF, 1'b0, 1'b0);
      if (i == 7) chk("relock_w7", locked, 0);
      if (i == 8) chk("relock_w8", locked, 1);
    end
    chk_cnt("relock", 25, 19);
    gen(w); step(w, 1'b1, 1'b0);
    chk_cnt("relock1", 25, 20);
    chk("sat_err_a", 32'(s_err_cnt), 15);
    chk("sat_wc_a", 32'(s_word_cnt), 15);

    // mid-operation reset beats valid and clear, then stuck line
    rst = 1'b1;
    step(10'h3FF, 1'b1, 1'b1);
    chk("mid_rst_locked", locked, 0); chk("mid_rst_flag", err_flag, 0);
    chk_cnt("mid_rst", 0, 0);
    rst = 1'b0;
    seen_lock = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(10'h3FF, 1'b1, 1'b0);
      seen_lock = seen_lock | locked;
    end
    chk("stuck_lock", seen_lock, 0);
    chk_cnt("stuck", 0, 0);

    // saturation and clear priority
    rst = 1'b1; step(10'h000, 1'b0, 1'b0); rst = 1'b0;
    gs = 9'h0F3;
    for (int i = 0; i < 9; i++) begin gen(w); step(w, 1'b1, 1'b0); end
    chk("sat_locked", s_locked, 1);
    for (int k = 1; k <= 4; k++) begin
      gen(w); step(w ^ 10'h01F, 1'b1, 1'b0);
      chk("sat_small", 32'(s_err_cnt), (5 * k > 15) ? 15 : 5 * k);
      chk("sat_big", err_cnt, 5 * k);
      gen(w); step(w, 1'b1, 1'b0);
    end
    chk("sat_wc", 32'(s_word_cnt), 8);
    gen(w); step(w ^ 10'h001, 1'b1, 1'b1);
    chk("clr_s_err", 32'(s_err_cnt), 0); chk("clr_s_wc", 32'(s_word_cnt), 0);
    chk_cnt("clr", 0, 0);
    chk("clr_locked", locked, 1); chk("clr_flag", err_flag, 1);
    clear_cnt = 1'b0;
    gen(w); step(w, 1'b1, 1'b0);
    chk_cnt("post_clr", 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
